// File: rtl/glip_out_arbiter_pkg.sv
// Shared types and frame layout for the GLIP outbound channel arbiter
// and the host-side frame parser.
package glip_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HEADER  = 2'd2,
    DATA    = 2'd3
  } arb_state_e;

  localparam int HDR_CH_MSB  = 15;
  localparam int HDR_CH_LSB  = 8;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/glip_out_arbiter_if.sv
// Requester-side and backend-side handshake signals of the outbound arbiter.
// The master modport is the environment (requesters plus backend FIFO).
// The slave modport is the arbiter itself.
interface glip_out_arbiter_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0]    req_valid;
  logic [NCH*16-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              fifo_out_valid;
  logic [15:0]       fifo_out_data;
  logic              fifo_out_ready;

  modport master (
    output req_valid, req_data, fifo_out_ready,
    input  req_ready, fifo_out_valid, fifo_out_data
  );

  modport slave (
    input  req_valid, req_data, fifo_out_ready,
    output req_ready, fifo_out_valid, fifo_out_data
  );
endinterface

// File: rtl/glip_out_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
// It scans ptr_i, ptr_i+1, ... modulo NCH, and reports the first set request bit.
module glip_rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [IW-1:0]  idx_o,
  output logic           found_o
);

  // Walk the ring once from the pointer and latch onto the first requester seen.
  always_comb begin
    int cand;
    cand    = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NCH) cand = cand - NCH;
      if (!found_o && req_i[IW'(cand)]) begin
        idx_o   = IW'(cand);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glip_out_arbiter.sv
// Outbound arbiter for the GLIP FIFO stream.
// It grants requesters round-robin and collects up to MAX_BURST words per grant.
// It then emits a header word {channel, length} followed by the buffered words.
module glip_out_arbiter
  import glip_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 64
) (
  input logic               clk,
  input logic               rst,
  glip_out_arbiter_if.slave bus
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int AW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  rrPtr_q, rrPtr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  rdPtr_q, rdPtr_d;
  logic [15:0]    wordBuf_q [MAX_BURST];

  logic [15:0]    reqWord [NCH];
  logic           bufWe;
  logic [GW-1:0]  pickIdx;
  logic           pickFound;
  logic [NCH-1:0] reqReady;
  logic           outValid;
  logic [15:0]    outData;
  logic [15:0]    hdrWord;

  glip_rr_pick #(
    .NCH (NCH),
    .IW  (GW)
  ) uPick (
    .req_i   (bus.req_valid),
    .ptr_i   (rrPtr_q),
    .idx_o   (pickIdx),
    .found_o (pickFound)
  );

  // Split the flat request data bus into one 16-bit word per channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      reqWord[i] = bus.req_data[16*i +: 16];
    end
  end

  // Assemble the frame header from the granted channel and the collected length.
  always_comb begin
    hdrWord = '0;
    hdrWord[HDR_CH_MSB:HDR_CH_LSB]   = 8'(grant_q);
    hdrWord[HDR_LEN_MSB:HDR_LEN_LSB] = 8'(count_q);
  end

  // Next-state logic and handshake outputs of the frame FSM.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rrPtr_d  = rrPtr_q;
    count_d  = count_q;
    rdPtr_d  = rdPtr_q;
    bufWe    = 1'b0;
    reqReady = '0;
    outValid = 1'b0;
    outData  = '0;
    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d = pickIdx;
          count_d = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        reqReady[grant_q] = 1'b1;
        if (bus.req_valid[grant_q]) begin
          bufWe   = 1'b1;
          count_d = count_q + CW'(1);
          if ((count_q + CW'(1)) == CW'(MAX_BURST)) state_d = HEADER;
        end else if (count_q != '0) begin
          state_d = HEADER;
        end
      end
      HEADER: begin
        outValid = 1'b1;
        outData  = hdrWord;
        if (bus.fifo_out_ready) begin
          rdPtr_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        outValid = 1'b1;
        outData  = wordBuf_q[rdPtr_q[AW-1:0]];
        if (bus.fifo_out_ready) begin
          rdPtr_d = rdPtr_q + CW'(1);
          if (rdPtr_q == (count_q - CW'(1))) begin
            state_d = IDLE;
            rrPtr_d = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and pointer registers; reset drops any partially collected or emitted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rrPtr_q <= '0;
      count_q <= '0;
      rdPtr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
      count_q <= count_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Burst buffer; stale contents are harmless because only words below count are read.
  always_ff @(posedge clk) begin
    if (bufWe) wordBuf_q[count_q[AW-1:0]] <= reqWord[grant_q];
  end

  assign bus.req_ready      = reqReady;
  assign bus.fifo_out_valid = outValid;
  assign bus.fifo_out_data  = outData;

endmodule
